logic_op_sequencer: RTL and testbench

Initiator side of the 8-bit logic unit. The block accepts operation requests (opcode, A, B) over a valid/ready input, buffers them in a DEPTH-entry FIFO, and issues one per cycle to the external combinational logic unit. It captures the returned result into an output register and presents it, tagged with status flags, over a valid/ready output.

---
 rtl/logic_op_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 78 +++++++
 rtl/logic_op_sequencer.sv | 124 ++++++++++++
 tb/tb_logic_op_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_op_pkg.sv
// Shared definitions for the logic-unit sequencer: opcode map, request record
// and the opcode legality helper.
package logic_op_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_NAND = 8'h04;
  localparam logic [7:0] OP_NOR  = 8'h05;
  localparam logic [7:0] OP_XNOR = 8'h06;
  localparam logic [7:0] OP_NOT  = 8'h07;

  typedef struct packed {
    logic [7:0]        opcode;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } logic_req_t;

  function automatic logic is_legal_op(input logic [7:0] op);
    return (op >= OP_AND) && (op <= OP_NOT);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with head-of-queue read-out; full/empty derive from count.
// Push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_s, pop_s;

  assign push_s = push && (count_q != CNT_FULL) && !flush;
  assign pop_s  = pop && (count_q != {CNT_W{1'b0}}) && !flush;
  assign rdata  = mem_q[rd_ptr_q];
  assign count  = count_q;

  // Pointer and occupancy next-state; flush empties the queue.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_d = wr_ptr_q + PTR_ONE;
      else        wr_ptr_d = wr_ptr_q;
      if (pop_s)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      else        rd_ptr_d = rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/logic_op_sequencer.sv
// Buffers logic-unit requests, issues one per cycle to the external unit and
// registers each result with zero/illegal status behind a valid/ready output.
module logic_op_sequencer
  import logic_op_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_opcode,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic [7:0]   lu_opcode,
  output logic [W-1:0] lu_a,
  output logic [W-1:0] lu_b,
  input  logic [W-1:0] lu_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_y,
  output logic [7:0]   out_opcode,
  output logic         out_zero,
  output logic         out_illegal,
  output logic [15:0]  issued_cnt
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic_req_t       wr_req_s, head_s;
  logic [CNT_W-1:0] fifo_count_s;
  logic             fifo_empty_s, push_s, issue_s, illegal_s;
  logic [W-1:0]     result_s;

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_y_q, out_y_d;
  logic [7:0]   out_opcode_q, out_opcode_d;
  logic         out_zero_q, out_zero_d;
  logic         out_illegal_q, out_illegal_d;
  logic [15:0]  issued_cnt_q, issued_cnt_d;

  assign wr_req_s = '{opcode: in_opcode, a: in_a, b: in_b};

  sync_fifo #(
    .WIDTH ($bits(logic_req_t)),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push_s),
    .wdata (wr_req_s),
    .pop   (issue_s),
    .rdata (head_s),
    .count (fifo_count_s)
  );

  assign fifo_empty_s = (fifo_count_s == {CNT_W{1'b0}});
  assign in_ready     = (fifo_count_s != CNT_FULL) && !flush;
  assign push_s       = in_valid && in_ready;
  assign issue_s      = !fifo_empty_s && (!out_valid_q || out_ready) && !flush;

  // The stale head slot is masked so the logic unit sees zeros when idle.
  assign lu_opcode = fifo_empty_s ? 8'h00 : head_s.opcode;
  assign lu_a      = fifo_empty_s ? {W{1'b0}} : head_s.a;
  assign lu_b      = fifo_empty_s ? {W{1'b0}} : head_s.b;

  assign illegal_s = !is_legal_op(head_s.opcode);
  assign result_s  = illegal_s ? {W{1'b0}} : lu_y;

  // Output register next-state: flush drops the result, issue loads, consume clears.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_y_d       = out_y_q;
    out_opcode_d  = out_opcode_q;
    out_zero_d    = out_zero_q;
    out_illegal_d = out_illegal_q;
    issued_cnt_d  = issued_cnt_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (issue_s) begin
      out_valid_d   = 1'b1;
      out_y_d       = result_s;
      out_opcode_d  = head_s.opcode;
      out_zero_d    = (result_s == {W{1'b0}});
      out_illegal_d = illegal_s;
      issued_cnt_d  = issued_cnt_q + 16'd1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output and issue-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_y_q       <= {W{1'b0}};
      out_opcode_q  <= 8'h00;
      out_zero_q    <= 1'b0;
      out_illegal_q <= 1'b0;
      issued_cnt_q  <= 16'd0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_y_q       <= out_y_d;
      out_opcode_q  <= out_opcode_d;
      out_zero_q    <= out_zero_d;
      out_illegal_q <= out_illegal_d;
      issued_cnt_q  <= issued_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_y       = out_y_q;
  assign out_opcode  = out_opcode_q;
  assign out_zero    = out_zero_q;
  assign out_illegal = out_illegal_q;
  assign issued_cnt  = issued_cnt_q;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Bench for logic_op_sequencer: directed scenarios plus a randomized run, all
// checked against a queue-based request/result model.
module tb_logic_op_sequencer;

  localparam int DEPTH = 4;
  localparam int W     = 8;

  logic         clk = 1'b0;
  logic         rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]   in_opcode, lu_opcode, out_opcode;
  logic [W-1:0] in_a, in_b, lu_a, lu_b, lu_y, out_y;
  logic         out_zero, out_illegal;
  logic [15:0]  issued_cnt;
  bit           lu_garbage = 1'b0;

  always #5 clk = ~clk;

  logic_op_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b),
    .lu_opcode(lu_opcode), .lu_a(lu_a), .lu_b(lu_b), .lu_y(lu_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_opcode(out_opcode), .out_zero(out_zero), .out_illegal(out_illegal),
    .issued_cnt(issued_cnt)
  );

  // External logic unit; can return junk for illegal codes to prove masking.
  always_comb begin
    case (lu_opcode)
      8'h01:   lu_y = lu_a & lu_b;
      8'h02:   lu_y = lu_a | lu_b;
      8'h03:   lu_y = lu_a ^ lu_b;
      8'h04:   lu_y = ~(lu_a & lu_b);
      8'h05:   lu_y = ~(lu_a | lu_b);
      8'h06:   lu_y = ~(lu_a ^ lu_b);
      8'h07:   lu_y = ~lu_a;
      default: lu_y = lu_garbage ? 8'hA5 : 8'h00;
    endcase
  end

  typedef struct { logic [7:0] op; logic [7:0] a; logic [7:0] b; } req_t;

  req_t        mq[$];
  bit          m_oval, m_oz, m_oill;
  logic [7:0]  m_oy, m_oop;
  logic [15:0] m_cnt;
  int          passed = 0, total = 0;
  bit          seen_ready, exp_ready;
  logic [7:0]  seen_lu_op;

  function automatic logic [7:0] ref_op(input logic [7:0] op, a, b);
    case (op)
      8'h01:   return a & b;
      8'h02:   return a | b;
      8'h03:   return a ^ b;
      8'h04:   return ~(a & b);
      8'h05:   return ~(a | b);
      8'h06:   return ~(a ^ b);
      8'h07:   return ~a;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_oval = 1'b0; m_oz = 1'b0; m_oill = 1'b0;
    m_oy = 8'h00; m_oop = 8'h00; m_cnt = 16'd0;
  endtask

  // Drive one cycle, sample pre-edge combinational outputs, advance the model.
  task automatic drive_cycle(input bit v, input logic [7:0] op, a, b, input bit rdy, fl);
    req_t r;
    bit   push;
    in_valid = v; in_opcode = op; in_a = a; in_b = b; out_ready = rdy; flush = fl;
    #1;
    seen_ready = in_ready;
    seen_lu_op = lu_opcode;
    exp_ready  = (mq.size() != DEPTH) && !fl;
    push       = v && exp_ready;
    if (fl) begin
      mq.delete();
      m_oval = 1'b0;
    end else begin
      if (mq.size() != 0 && (!m_oval || rdy)) begin
        r      = mq.pop_front();
        m_oill = !(r.op >= 8'd1 && r.op <= 8'd7);
        m_oy   = m_oill ? 8'h00 : ref_op(r.op, r.a, r.b);
        m_oop  = r.op;
        m_oz   = (m_oy == 8'h00);
        m_oval = 1'b1;
        m_cnt  = m_cnt + 16'd1;
      end else if (m_oval && rdy) begin
        m_oval = 1'b0;
      end
      if (push) begin
        r.op = op; r.a = a; r.b = b;
        mq.push_back(r);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy);
    drive_cycle(1'b0, 8'h00, 8'h00, 8'h00, rdy, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = 8'h00; in_a = 8'h00; in_b = 8'h00;
    model_reset();
    #2;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else passed++;
    total++; if ({out_y, out_opcode, out_zero, out_illegal} !== 18'h0) $display("FAIL reset_outdata got %h/%h exp 0", out_y, out_opcode); else passed++;
    total++; if (issued_cnt !== 16'd0) $display("FAIL reset_cnt got %0d exp 0", issued_cnt); else passed++;
    total++; if ({lu_opcode, lu_a, lu_b} !== 24'h0) $display("FAIL reset_lu got %h %h %h exp 0", lu_opcode, lu_a, lu_b); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else passed++;
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_and();
    drive_cycle(1'b1, 8'h01, 8'hF0, 8'h3C, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b0) $display("FAIL and_no_fallthrough got %b exp 0", out_valid); else passed++;
    idle(1'b1);
    total++; if (out_valid !== 1'b1) $display("FAIL and_valid got %b exp 1", out_valid); else passed++;
    total++; if (out_y !== 8'h30) $display("FAIL and_y got %h exp 30", out_y); else passed++;
    total++; if (out_opcode !== 8'h01) $display("FAIL and_opcode got %h exp 01", out_opcode); else passed++;
    total++; if ({out_zero, out_illegal} !== 2'b00) $display("FAIL and_flags got %b exp 00", {out_zero, out_illegal}); else passed++;
    total++; if (issued_cnt !== 16'd1) $display("FAIL and_cnt got %0d exp 1", issued_cnt); else passed++;
    idle(1'b1);
    total++; if (out_valid !== 1'b0) $display("FAIL and_consumed got %b exp 0", out_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    drive_cycle(1'b1, 8'h07, 8'hA5, 8'hFF, 1'b1, 1'b0);
    drive_cycle(1'b1, 8'h03, 8'h55, 8'h55, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b1 || out_y !== 8'h5A) $display("FAIL b2b_not got v=%b y=%h exp v=1 y=5a", out_valid, out_y); else passed++;
    idle(1'b1);
    total++; if (out_valid !== 1'b1 || out_y !== 8'h00) $display("FAIL b2b_xor got v=%b y=%h exp v=1 y=00", out_valid, out_y); else passed++;
    total++; if (out_zero !== 1'b1) $display("FAIL b2b_zero got %b exp 1", out_zero); else passed++;
    idle(1'b1);
    total++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got %b exp 0", out_valid); else passed++;
  endtask

  task automatic test_illegal();
    lu_garbage = 1'b1;
    drive_cycle(1'b1, 8'h08, 8'hFF, 8'hFF, 1'b1, 1'b0);
    idle(1'b1);
    total++; if (seen_lu_op !== 8'h08) $display("FAIL ill_lu_opcode got %h exp 08", seen_lu_op); else passed++;
    total++; if (out_y !== 8'h00) $display("FAIL ill_y got %h exp 00", out_y); else passed++;
    total++; if ({out_illegal, out_zero} !== 2'b11) $display("FAIL ill_flags got %b exp 11", {out_illegal, out_zero}); else passed++;
    total++; if (out_opcode !== 8'h08) $display("FAIL ill_opcode got %h exp 08", out_opcode); else passed++;
    lu_garbage = 1'b0;
    idle(1'b1);
  endtask

  task automatic test_capacity();
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, 8'h02, 8'(i), 8'h80, 1'b0, 1'b0);
      total++; if (seen_ready !== (i < 5)) $display("FAIL cap_accept_%0d got %b exp %b", i, seen_ready, (i < 5)); else passed++;
    end
    total++; if (in_ready !== 1'b0) $display("FAIL cap_full_ready got %b exp 0", in_ready); else passed++;
    total++; if (out_valid !== 1'b1 || out_y !== 8'h80) $display("FAIL cap_head got v=%b y=%h exp v=1 y=80", out_valid, out_y); else passed++;
    for (int j = 1; j <= 4; j++) begin
      idle(1'b1);
      total++; if (out_valid !== 1'b1 || out_y !== 8'(8'h80 + j)) $display("FAIL cap_drain_%0d got v=%b y=%h exp v=1 y=%h", j, out_valid, out_y, 8'(8'h80 + j)); else passed++;
      if (j == 1) begin
        total++; if (in_ready !== 1'b1) $display("FAIL cap_ready_back got %b exp 1", in_ready); else passed++;
      end
    end
    idle(1'b1);
    total++; if (out_valid !== 1'b0) $display("FAIL cap_empty got %b exp 0", out_valid); else passed++;
    total++; if (issued_cnt !== m_cnt) $display("FAIL cap_cnt got %0d exp %0d", issued_cnt, m_cnt); else passed++;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 8'h01, 8'(i + 1), 8'hFF, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b1) $display("FAIL flush_pre_valid got %b exp 1", out_valid); else passed++;
    drive_cycle(1'b1, 8'h02, 8'h11, 8'h22, 1'b0, 1'b1);
    flush = 1'b0; in_valid = 1'b0; #1;
    total++; if (out_valid !== 1'b0) $display("FAIL flush_valid got %b exp 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL flush_ready got %b exp 1", in_ready); else passed++;
    total++; if (lu_opcode !== 8'h00) $display("FAIL flush_empty got lu_opcode %h exp 00", lu_opcode); else passed++;
    total++; if (issued_cnt !== m_cnt) $display("FAIL flush_cnt got %0d exp %0d", issued_cnt, m_cnt); else passed++;
    idle(1'b1);
    total++; if (out_valid !== 1'b0) $display("FAIL flush_push_lost got %b exp 0", out_valid); else passed++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'h06, 8'h0F, 8'(i), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    total++; if ({out_valid, out_y, out_opcode, out_zero, out_illegal} !== 19'h0) $display("FAIL areset_out got v=%b y=%h op=%h", out_valid, out_y, out_opcode); else passed++;
    total++; if (issued_cnt !== 16'd0) $display("FAIL areset_cnt got %0d exp 0", issued_cnt); else passed++;
    total++; if ({lu_opcode, lu_a, lu_b} !== 24'h0) $display("FAIL areset_lu got %h %h %h exp 0", lu_opcode, lu_a, lu_b); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL areset_ready got %b exp 1", in_ready); else passed++;
    model_reset();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_cycle(1'b1, 8'h04, 8'hFF, 8'h0F, 1'b1, 1'b0);
    idle(1'b1);
    total++; if (out_valid !== 1'b1 || out_y !== 8'hF0) $display("FAIL areset_nand got v=%b y=%h exp v=1 y=f0", out_valid, out_y); else passed++;
    total++; if (issued_cnt !== 16'd1) $display("FAIL areset_nand_cnt got %0d exp 1", issued_cnt); else passed++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      lu_garbage = 1'($urandom_range(0, 1));
      drive_cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 9)), 8'($urandom),
                  8'($urandom), 1'($urandom_range(0, 2) != 0), $urandom_range(0, 29) == 0);
      total++; if (seen_ready !== exp_ready) $display("FAIL rnd_ready@%0d got %b exp %b", n, seen_ready, exp_ready); else passed++;
      total++; if (out_valid !== m_oval) $display("FAIL rnd_valid@%0d got %b exp %b", n, out_valid, m_oval); else passed++;
      total++; if (issued_cnt !== m_cnt) $display("FAIL rnd_cnt@%0d got %0d exp %0d", n, issued_cnt, m_cnt); else passed++;
      if (m_oval) begin
        total++;
        if ({out_y, out_opcode, out_zero, out_illegal} !== {m_oy, m_oop, m_oz, m_oill})
          $display("FAIL rnd_data@%0d got %h/%h/%b%b exp %h/%h/%b%b", n, out_y, out_opcode,
                   out_zero, out_illegal, m_oy, m_oop, m_oz, m_oill);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_and();
    test_back_to_back();
    test_illegal();
    test_capacity();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
